// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals of the two-requester ALU arbiter.
// The slave modport is the arbiter side; master is the requester/ALU/consumer side.
interface alu_arbiter_if;
  localparam int unsigned DW  = 16;
  localparam int unsigned OPW = 3;
  localparam int unsigned FW  = 3;

  logic           i_flush;
  logic           i_req0_valid;
  logic           i_req1_valid;
  logic [OPW-1:0] i_req0_op;
  logic [OPW-1:0] i_req1_op;
  logic [DW-1:0]  i_req0_a;
  logic [DW-1:0]  i_req0_b;
  logic [DW-1:0]  i_req1_a;
  logic [DW-1:0]  i_req1_b;
  logic           i_req0_upd;
  logic           i_req1_upd;
  logic           o_req0_ready;
  logic           o_req1_ready;
  logic [DW-1:0]  o_alu_data_1;
  logic [DW-1:0]  o_alu_data_2;
  logic [OPW-1:0] o_alu_op;
  logic           o_alu_zero;
  logic           o_alu_negative;
  logic           o_alu_carry;
  logic [DW-1:0]  i_alu_result;
  logic           i_alu_zero;
  logic           i_alu_negative;
  logic           i_alu_carry;
  logic           i_flag_restore;
  logic [FW-1:0]  i_flag_restore_val;
  logic           o_rsp_valid;
  logic           o_rsp_id;
  logic [DW-1:0]  o_rsp_result;
  logic           i_rsp_ready;
  logic [FW-1:0]  o_ccr;

  modport slave (
    input  i_flush,
    input  i_req0_valid, i_req1_valid, i_req0_op, i_req1_op,
    input  i_req0_a, i_req0_b, i_req1_a, i_req1_b, i_req0_upd, i_req1_upd,
    output o_req0_ready, o_req1_ready,
    output o_alu_data_1, o_alu_data_2, o_alu_op,
    output o_alu_zero, o_alu_negative, o_alu_carry,
    input  i_alu_result, i_alu_zero, i_alu_negative, i_alu_carry,
    input  i_flag_restore, i_flag_restore_val,
    output o_rsp_valid, o_rsp_id, o_rsp_result,
    input  i_rsp_ready,
    output o_ccr
  );

  modport master (
    output i_flush,
    output i_req0_valid, i_req1_valid, i_req0_op, i_req1_op,
    output i_req0_a, i_req0_b, i_req1_a, i_req1_b, i_req0_upd, i_req1_upd,
    input  o_req0_ready, o_req1_ready,
    input  o_alu_data_1, o_alu_data_2, o_alu_op,
    input  o_alu_zero, o_alu_negative, o_alu_carry,
    output i_alu_result, i_alu_zero, i_alu_negative, i_alu_carry,
    output i_flag_restore, i_flag_restore_val,
    input  o_rsp_valid, o_rsp_id, o_rsp_result,
    output i_rsp_ready,
    input  o_ccr
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of an external combinational ALU: an issue stage
// drives the ALU, a response stage captures its result, and a CCR holds committed flags.
module alu_arbiter #(
  parameter int unsigned RR_ENABLE = 1
) (
  input logic          i_clk,
  input logic          i_rst_n,
  alu_arbiter_if.slave bus
);
  localparam int unsigned DW  = 16;
  localparam int unsigned OPW = 3;
  localparam int unsigned FW  = 3;
  localparam bit          RR  = (RR_ENABLE != 0);

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic           id;
    logic           upd;
  } iss_t;

  logic          ptr;
  logic          iss_valid;
  iss_t          iss;
  logic          rsp_valid;
  logic          rsp_id;
  logic [DW-1:0] rsp_result;
  logic [FW-1:0] ccr;

  logic grant0_c;
  logic grant1_c;
  logic rsp_load_c;
  logic advance_c;
  logic accept_c;
  iss_t req_c;

  // Grant selection and pipeline advance; flush blocks any acceptance.
  always_comb begin
    grant1_c   = bus.i_req1_valid && (!bus.i_req0_valid || (RR && ptr));
    grant0_c   = bus.i_req0_valid && !grant1_c;
    rsp_load_c = !rsp_valid || bus.i_rsp_ready;
    advance_c  = (!iss_valid || rsp_load_c) && !bus.i_flush;
    accept_c   = (grant0_c || grant1_c) && advance_c;
    req_c      = '{op: bus.i_req0_op, a: bus.i_req0_a, b: bus.i_req0_b,
                   id: 1'b0, upd: bus.i_req0_upd};
    if (grant1_c) begin
      req_c = '{op: bus.i_req1_op, a: bus.i_req1_a, b: bus.i_req1_b,
                id: 1'b1, upd: bus.i_req1_upd};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr        <= 1'b0;
      iss_valid  <= 1'b0;
      iss        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      ccr        <= '0;
    end else begin
      if (bus.i_flush) begin
        iss_valid <= 1'b0;
        iss.op    <= '0;
        rsp_valid <= 1'b0;
      end else begin
        if (advance_c) begin
          iss_valid <= accept_c;
          if (accept_c) begin
            iss <= req_c;
            ptr <= ~req_c.id;
          end else begin
            iss.op <= '0;
          end
        end
        if (rsp_load_c) begin
          rsp_valid <= iss_valid;
          if (iss_valid) begin
            rsp_result <= bus.i_alu_result;
            rsp_id     <= iss.id;
          end
        end
      end
      // Restore wins over a flag commit on the same edge; flushed ops never commit.
      if (bus.i_flag_restore) begin
        ccr <= bus.i_flag_restore_val;
      end else if (!bus.i_flush && iss_valid && iss.upd && rsp_load_c) begin
        ccr <= {bus.i_alu_carry, bus.i_alu_negative, bus.i_alu_zero};
      end
    end
  end

  assign bus.o_req0_ready   = grant0_c && advance_c;
  assign bus.o_req1_ready   = grant1_c && advance_c;
  assign bus.o_alu_data_1   = iss.a;
  assign bus.o_alu_data_2   = iss.b;
  assign bus.o_alu_op       = iss.op;
  assign bus.o_alu_carry    = ccr[2];
  assign bus.o_alu_negative = ccr[1];
  assign bus.o_alu_zero     = ccr[0];
  assign bus.o_rsp_valid    = rsp_valid;
  assign bus.o_rsp_id       = rsp_id;
  assign bus.o_rsp_result   = rsp_result;
  assign bus.o_ccr          = ccr;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: per-requester expected queues filled at issue,
// drained by a monitor that checks results and CCR against an arithmetic ALU/CCR model.
module tb_alu_arbiter;
  localparam int unsigned DW = 16;

  typedef struct packed {
    logic          id;
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          upd;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if bus();
  alu_arbiter_if bus_fp();

  alu_arbiter #(.RR_ENABLE(1)) dut    (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  alu_arbiter #(.RR_ENABLE(0)) dut_fp (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_fp));

  int   n_tests = 0;
  int   n_fail  = 0;
  txn_t exp_q0[$];
  txn_t exp_q1[$];
  logic ord_q[$];
  logic [2:0] m_ccr;
  bit   ccr_chk;
  bit   done;

  // Returns {C,N,Z,result}; SUB is b - a with C as borrow, NOP passes b.
  function automatic logic [DW+2:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [DW:0]   w;
    logic [DW-1:0] r;
    logic          c;
    w = '0;
    c = 1'b0;
    case (op)
      3'd0: r = b;
      3'd1: r = ~a;
      3'd2: begin w = {1'b0, a} + {1'b0, b}; r = w[DW-1:0]; c = w[DW]; end
      3'd3: begin r = b - a; c = (a > b); end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a << b[3:0];
      default: r = a >> b[3:0];
    endcase
    return {c, r[DW-1], (r == '0), r};
  endfunction

  logic [DW+2:0] alu_o;
  logic [DW+2:0] alu_fp_o;
  assign alu_o    = alu_f(bus.o_alu_op, bus.o_alu_data_1, bus.o_alu_data_2);
  assign alu_fp_o = alu_f(bus_fp.o_alu_op, bus_fp.o_alu_data_1, bus_fp.o_alu_data_2);
  assign bus.i_alu_result      = alu_o[DW-1:0];
  assign bus.i_alu_zero        = alu_o[DW];
  assign bus.i_alu_negative    = alu_o[DW+1];
  assign bus.i_alu_carry       = alu_o[DW+2];
  assign bus_fp.i_alu_result   = alu_fp_o[DW-1:0];
  assign bus_fp.i_alu_zero     = alu_fp_o[DW];
  assign bus_fp.i_alu_negative = alu_fp_o[DW+1];
  assign bus_fp.i_alu_carry    = alu_fp_o[DW+2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, record its expectation, hold until accepted.
  task automatic send(input logic id, input logic [2:0] op, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic upd);
    txn_t t;
    int   w;
    logic acc;
    t.id = id; t.op = op; t.a = a; t.b = b; t.upd = upd;
    if (id) begin
      exp_q1.push_back(t);
      bus.i_req1_op = op; bus.i_req1_a = a; bus.i_req1_b = b; bus.i_req1_upd = upd;
      bus.i_req1_valid = 1'b1;
    end else begin
      exp_q0.push_back(t);
      bus.i_req0_op = op; bus.i_req0_a = a; bus.i_req0_b = b; bus.i_req0_upd = upd;
      bus.i_req0_valid = 1'b1;
    end
    w = 0;
    acc = 1'b0;
    while (!acc && w < 300) begin
      @(negedge clk);
      acc = id ? bus.o_req1_ready : bus.o_req0_ready;
      w++;
    end
    check("accept", 32'(acc), 32'd1);
    @(posedge clk);
    #1;
    if (id) bus.i_req1_valid = 1'b0;
    else    bus.i_req0_valid = 1'b0;
  endtask

  task automatic send_rand(input logic id);
    send(id, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
  endtask

  // Monitor: handshake invariants each cycle, scoreboard pop on each consumed response.
  initial begin
    txn_t          t;
    logic [DW+2:0] f;
    bit            have;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("one_ready", 32'(bus.o_req0_ready & bus.o_req1_ready), 32'd0);
        check("ready_wo_valid", 32'((bus.o_req0_ready & ~bus.i_req0_valid) |
                                    (bus.o_req1_ready & ~bus.i_req1_valid)), 32'd0);
        if (bus.o_rsp_valid === 1'b1 && bus.i_rsp_ready === 1'b1) begin
          have = 1'b0;
          if (bus.o_rsp_id == 1'b0 && exp_q0.size() != 0) begin
            t = exp_q0.pop_front(); have = 1'b1;
          end else if (bus.o_rsp_id == 1'b1 && exp_q1.size() != 0) begin
            t = exp_q1.pop_front(); have = 1'b1;
          end
          check("rsp_expected", 32'(have), 32'd1);
          if (have) begin
            f = alu_f(t.op, t.a, t.b);
            if (t.upd) m_ccr = f[DW+2:DW];
            check("rsp_result", 32'(bus.o_rsp_result), 32'(f[DW-1:0]));
            if (ccr_chk) check("rsp_ccr", 32'(bus.o_ccr), 32'(m_ccr));
            if (ord_q.size() != 0) check("rsp_order", 32'(bus.o_rsp_id), 32'(ord_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int w;
    txn_t z;
    rst_n = 1'b0;
    m_ccr = 3'b000;
    ccr_chk = 1'b1;
    done = 1'b0;
    bus.i_flush = 1'b0; bus.i_flag_restore = 1'b0; bus.i_flag_restore_val = 3'b000;
    bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0; bus.i_rsp_ready = 1'b0;
    bus.i_req0_op = '0; bus.i_req0_a = '0; bus.i_req0_b = '0; bus.i_req0_upd = 1'b0;
    bus.i_req1_op = '0; bus.i_req1_a = '0; bus.i_req1_b = '0; bus.i_req1_upd = 1'b0;
    bus_fp.i_flush = 1'b0; bus_fp.i_flag_restore = 1'b0; bus_fp.i_flag_restore_val = 3'b000;
    bus_fp.i_req0_valid = 1'b0; bus_fp.i_req1_valid = 1'b0; bus_fp.i_rsp_ready = 1'b1;
    bus_fp.i_req0_op = 3'd2; bus_fp.i_req0_a = '0; bus_fp.i_req0_b = 16'h0001;
    bus_fp.i_req0_upd = 1'b0;
    bus_fp.i_req1_op = 3'd2; bus_fp.i_req1_a = 16'h0010; bus_fp.i_req1_b = 16'h0001;
    bus_fp.i_req1_upd = 1'b0;
    repeat (2) tick();
    check("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("rst_ccr", 32'(bus.o_ccr), 32'd0);
    check("rst_alu_op", 32'(bus.o_alu_op), 32'd0);
    check("rst_rsp_result", 32'(bus.o_rsp_result), 32'd0);

    // ADD 0x7FFF+1 presented across reset release: accepted on first edge, response two edges on.
    z = '{id: 1'b0, op: 3'd2, a: 16'h7FFF, b: 16'h0001, upd: 1'b1};
    exp_q0.push_back(z);
    bus.i_req0_op = 3'd2; bus.i_req0_a = 16'h7FFF; bus.i_req0_b = 16'h0001;
    bus.i_req0_upd = 1'b1; bus.i_req0_valid = 1'b1; bus.i_rsp_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    check("first_accept", 32'(bus.o_req0_ready), 32'd1);
    tick();
    bus.i_req0_valid = 1'b0;
    @(negedge clk);
    check("lat_edge1_valid", 32'(bus.o_rsp_valid), 32'd0);
    @(negedge clk);
    check("lat_edge2_valid", 32'(bus.o_rsp_valid), 32'd1);
    check("add_rsp_id", 32'(bus.o_rsp_id), 32'd0);
    check("add_result", 32'(bus.o_rsp_result), 32'h8000);
    check("add_ccr", 32'(bus.o_ccr), 32'b010);
    check("add_alu_neg", 32'(bus.o_alu_negative), 32'd1);
    tick();

    // Backpressure: two ops in flight, third waiting, consumer stalled three cycles.
    bus.i_rsp_ready = 1'b0;
    ord_q.push_back(1'b0); ord_q.push_back(1'b1); ord_q.push_back(1'b0);
    send(1'b0, 3'd4, 16'hF0F0, 16'h0FF0, 1'b1);
    send(1'b1, 3'd5, 16'h1200, 16'h0034, 1'b0);
    z = '{id: 1'b0, op: 3'd6, a: 16'h0001, b: 16'h000F, upd: 1'b1};
    exp_q0.push_back(z);
    bus.i_req0_op = 3'd6; bus.i_req0_a = 16'h0001; bus.i_req0_b = 16'h000F;
    bus.i_req0_upd = 1'b1; bus.i_req0_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
      check("bp_rsp_id", 32'(bus.o_rsp_id), 32'd0);
      check("bp_rsp_result", 32'(bus.o_rsp_result), 32'h00F0);
      check("bp_ready0", 32'(bus.o_req0_ready), 32'd0);
      check("bp_ready1", 32'(bus.o_req1_ready), 32'd0);
      tick();
    end
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_resume_ready", 32'(bus.o_req0_ready), 32'd1);
    tick();
    bus.i_req0_valid = 1'b0;
    repeat (4) tick();
    check("bp_order_drained", 32'(ord_q.size()), 32'd0);

    // SUB 5-5 commits on the same edge as a restore of 100: restore wins.
    ccr_chk = 1'b0;
    send(1'b0, 3'd3, 16'h0005, 16'h0005, 1'b1);
    bus.i_flag_restore = 1'b1; bus.i_flag_restore_val = 3'b100;
    tick();
    bus.i_flag_restore = 1'b0;
    check("restore_ccr", 32'(bus.o_ccr), 32'b100);
    tick();
    m_ccr = 3'b100;
    ccr_chk = 1'b1;
    check("restore_ccr_hold", 32'(bus.o_ccr), 32'b100);

    // Flush with ops in both stages: first op has committed, second must not.
    bus.i_rsp_ready = 1'b0;
    send(1'b0, 3'd2, 16'h7FFF, 16'h0001, 1'b1);
    send(1'b1, 3'd3, 16'h0005, 16'h0005, 1'b1);
    bus.i_req0_op = 3'd1; bus.i_req0_a = 16'h1111; bus.i_req0_valid = 1'b1;
    bus.i_flush = 1'b1;
    @(negedge clk);
    check("flush_ready0", 32'(bus.o_req0_ready), 32'd0);
    tick();
    bus.i_flush = 1'b0;
    bus.i_req0_valid = 1'b0;
    check("flush_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("flush_ccr", 32'(bus.o_ccr), 32'b010);
    exp_q0.delete(); exp_q1.delete();
    m_ccr = 3'b010;
    @(negedge clk);
    check("flush_alu_op", 32'(bus.o_alu_op), 32'd0);
    check("flush_rsp_valid2", 32'(bus.o_rsp_valid), 32'd0);
    bus.i_rsp_ready = 1'b1;
    tick();

    // Asynchronous reset mid-stream: outputs clear without an edge, nothing emerges after.
    send(1'b1, 3'd2, 16'h1234, 16'h1111, 1'b0);
    send(1'b0, 3'd5, 16'h00FF, 16'h0F00, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("arst_rsp_id", 32'(bus.o_rsp_id), 32'd0);
    check("arst_rsp_result", 32'(bus.o_rsp_result), 32'd0);
    check("arst_alu_op", 32'(bus.o_alu_op), 32'd0);
    check("arst_alu_data", 32'({bus.o_alu_data_1, bus.o_alu_data_2}), 32'd0);
    check("arst_ccr", 32'(bus.o_ccr), 32'd0);
    exp_q0.delete(); exp_q1.delete();
    m_ccr = 3'b000;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("arst_no_stray", 32'(bus.o_rsp_valid), 32'd0);
    end
    tick();

    // Round-robin with both requesters busy: strict alternation, one response per cycle.
    for (int k = 0; k < 8; k++) ord_q.push_back(1'(k % 2));
    fork
      begin
        for (int k = 0; k < 4; k++) send_rand(1'b0);
      end
      begin
        for (int k = 0; k < 4; k++) send_rand(1'b1);
      end
      begin
        w = 0;
        while (bus.o_rsp_valid !== 1'b1 && w < 50) begin
          @(negedge clk);
          w++;
        end
        for (int k = 0; k < 8; k++) begin
          check("b2b_valid", 32'(bus.o_rsp_valid), 32'd1);
          @(negedge clk);
        end
      end
    join
    repeat (3) tick();
    check("rr_order_drained", 32'(ord_q.size()), 32'd0);

    // Fixed priority: requester 0 wins every cycle while valid.
    bus_fp.i_req1_valid = 1'b1;
    bus_fp.i_req0_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("fp_ready0", 32'(bus_fp.o_req0_ready), 32'd1);
      check("fp_ready1", 32'(bus_fp.o_req1_ready), 32'd0);
      tick();
      bus_fp.i_req0_a = 16'(k + 1);
    end
    bus_fp.i_req0_valid = 1'b0;
    @(negedge clk);
    check("fp_ready1_last", 32'(bus_fp.o_req1_ready), 32'd1);
    tick();
    bus_fp.i_req1_valid = 1'b0;

    // Randomised traffic with random consumer backpressure.
    fork
      begin
        fork
          begin
            for (int k = 0; k < 50; k++) begin
              repeat ($urandom_range(0, 2)) tick();
              send_rand(1'b0);
            end
          end
          begin
            for (int k = 0; k < 50; k++) begin
              repeat ($urandom_range(0, 2)) tick();
              send_rand(1'b1);
            end
          end
        join
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.i_rsp_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    bus.i_rsp_ready = 1'b1;
    w = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && w < 100) begin
      tick();
      w++;
    end
    check("drain_q0", 32'(exp_q0.size()), 32'd0);
    check("drain_q1", 32'(exp_q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_ENABLE, default 1, meaning: 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_flush  input  1  synchronous clear of issue and response stages.
REQ-005 i_req0_valid / i_req1_valid  input  1 each  request present.
REQ-006 i_req0_op / i_req1_op  input  3 each  ALU opcode: 000 NOP, 001 NOT, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 SHL, 111 SHR.
REQ-007 i_req0_a, i_req0_b / i_req1_a, i_req1_b  input  16 each  operands (a = source, b = destination/shift amount).
REQ-008 i_req0_upd / i_req1_upd  input  1 each  commit resulting flags to CCR.
REQ-009 o_req0_ready / o_req1_ready  output  1 each  request accepted this cycle when valid & ready.
REQ-010 o_alu_data_1, o_alu_data_2  output  16  operands driven to the ALU from the issue stage.
REQ-011 o_alu_op  output  3  opcode driven to the ALU (000 when issue stage empty).
REQ-012 o_alu_zero, o_alu_negative, o_alu_carry  output  1 each  current CCR driven to the ALU flag inputs.
REQ-013 i_alu_result  input  16; i_alu_zero, i_alu_negative, i_alu_carry  input  1 each  combinational ALU outputs.
REQ-014 i_flag_restore  input  1; i_flag_restore_val  input  3 {C,N,Z}  load CCR (return-from-interrupt).
REQ-015 o_rsp_valid  output  1; o_rsp_id  output  1 (requester index); o_rsp_result  output  16; i_rsp_ready  input  1.
REQ-016 o_ccr  output  3  CCR {C,N,Z}.

Function
REQ-017 Two-stage pipeline: issue stage (registered op, operands, id, upd, valid) feeds the ALU; response stage registers the ALU result, id and valid.
REQ-018 Issue stage advances when empty or when the response stage is empty or i_rsp_ready=1.
REQ-019 o_reqK_ready = grantK & issue-advance condition; at most one ready high per cycle; ready never high for an invalid requester.
REQ-020 Grant: only one valid -> that one; both valid -> pointer selects; RR_ENABLE=0 -> requester 0 always.
REQ-021 Pointer updates only on an accepted request, to the non-granted requester; reset value 0.
REQ-022 Latency: request accepted at edge N -> o_rsp_valid high from edge N+2 with o_rsp_result = ALU output for the request's operands and the CCR value at edge N+1.
REQ-023 Response held stable (valid, id, result) until i_rsp_ready=1; back-to-back accepts sustain one response per cycle when i_rsp_ready=1.
REQ-024 CCR loads {i_alu_carry, i_alu_negative, i_alu_zero} on the edge the issue stage moves into the response stage, when issue upd=1.
REQ-025 i_flag_restore=1 loads i_flag_restore_val into CCR, overriding a simultaneous ALU flag commit.
REQ-026 Back-to-back dependent ops: second op sees flags committed by the first (no stale CCR).
REQ-027 i_flush=1: issue and response valid cleared next edge, no ready asserted that cycle, CCR and pointer unchanged, flushed ops never commit flags.
REQ-028 Requesters hold valid and payload stable until accepted; arbiter behaviour otherwise undefined.

Reset
REQ-029 i_rst_n=0 immediately (asynchronously) clears issue/response valids, pointer=0, CCR=000, o_rsp_result=0, o_rsp_id=0, o_alu_op=000, o_alu_data_1/2=0.
REQ-030 Reset mid-operation discards all in-flight ops; no response emerges after release.
REQ-031 First accept possible on the first rising edge after i_rst_n deasserts.

Verification
REQ-032 Req0 ADD a=0x7FFF b=0x0001 upd=1, i_rsp_ready=1 -> two edges later rsp id=0 result=0x8000, CCR=010 (C=0,N=1,Z=0).
REQ-033 Both valid continuously, RR_ENABLE=1, four ops -> grant order 0,1,0,1; RR_ENABLE=0 -> 0,0,0,0 while req0 stays valid.
REQ-034 i_rsp_ready=0 for 3 cycles with two ops in flight -> response held unchanged, both readys low, no op lost, order preserved after release.
REQ-035 SUB 0x0005-0x0005 upd=1 committing same edge as i_flag_restore=1 val=100 -> CCR=100.
REQ-036 i_rst_n pulsed low mid-stream -> outputs per REQ-029 without a clock edge, no stray o_rsp_valid afterwards.
REQ-037 i_flush with ops in both stages -> o_rsp_valid=0 next cycle, CCR unchanged.
